// File: rtl/freecell_if.sv
// Request/response bundle for freecell_engine: board loading, move requests,
// move responses and game status. master drives requests, slave is the engine.
interface freecell_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
);
    logic               clear;
    logic               load_valid;
    logic               load_ready;
    logic [IDX_W-1:0]   load_col;
    logic [5:0]         load_card;
    logic               load_err;
    logic               move_valid;
    logic               move_ready;
    logic [IDX_W+1:0]   move_src;
    logic [IDX_W+1:0]   move_dst;
    logic               resp_valid;
    logic               resp_legal;
    logic [2:0]         resp_code;
    logic [CNT_W-1:0]   move_count;
    logic               win;
    logic               busy;

    modport master (
        output clear, load_valid, load_col, load_card, move_valid, move_src, move_dst,
        input  load_ready, load_err, move_ready, resp_valid, resp_legal, resp_code,
               move_count, win, busy
    );

    modport slave (
        input  clear, load_valid, load_col, load_card, move_valid, move_src, move_dst,
        output load_ready, load_err, move_ready, resp_valid, resp_legal, resp_code,
               move_count, win, busy
    );
endinterface

// File: rtl/freecell_engine.sv
// freecell_engine: holds a FreeCell board (tableau, free cells, home piles),
// accepts column loads and move requests, answers each move with a one-cycle
// legality response, counts legal moves and flags a win.
// Optional feature: define FREECELL_AUTO_HOME_EN to sweep eligible cards home
// after every legal move (AUTO state) before the response is given.
module freecell_engine #(
    parameter int NUM_COLS  = 8,
    parameter int COL_DEPTH = 19,
    parameter int NUM_FREE  = 4,
    parameter int IDX_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic      clock,
    input  logic      reset,
    freecell_if.slave bus
);
    localparam int HW = $clog2(COL_DEPTH + 1);
    localparam int DW = (COL_DEPTH > 1) ? $clog2(COL_DEPTH) : 1;
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int FW = (NUM_FREE > 1) ? $clog2(NUM_FREE) : 1;
    localparam logic [1:0] T_TAB  = 2'b00;
    localparam logic [1:0] T_BAD  = 2'b01;
    localparam logic [1:0] T_FREE = 2'b10;
    localparam logic [1:0] T_HOME = 2'b11;

`ifdef FREECELL_AUTO_HOME_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_RESP = 2'd2, S_AUTO = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_RESP = 2'd2} state_t;
`endif

    // index fits below a parameter limit (compared at 32 bits so IDX_W may be narrow)
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx, input int lim);
        return ({{(32-IDX_W){1'b0}}, idx} < 32'(lim));
    endfunction

    state_t state_r, state_next_s;
    logic [5:0]       col_r    [NUM_COLS][COL_DEPTH];
    logic [HW-1:0]    height_r [NUM_COLS];
    logic [5:0]       free_r   [NUM_FREE];
    logic [3:0]       home_r   [4];
    logic [5:0]       top_s    [NUM_COLS];
    logic [IDX_W+1:0] src_r, dst_r;
    logic             ready_r, busy_r, resp_valid_r, resp_legal_r, load_err_r, win_r;
    logic [2:0]       resp_code_r, code_s;
    logic [CNT_W-1:0] count_r;

    logic             move_fire_s, clear_fire_s, load_fire_s, load_bad_s, load_ok_s;
    logic [CW-1:0]    load_c_s, src_c_s, dst_c_s;
    logic [FW-1:0]    src_f_s, dst_f_s;
    logic [1:0]       src_type_s, dst_type_s;
    logic             src_col_ok_s, dst_col_ok_s, src_free_ok_s, dst_free_ok_s;
    logic [5:0]       src_card_s, dst_top_s;
    logic             bad_s, dst_full_s, fits_s, legal_s, commit_s, auto_move_s;

    assign move_fire_s  = bus.move_valid && ready_r;
    assign clear_fire_s = bus.clear && ready_r && !move_fire_s;
    assign load_fire_s  = bus.load_valid && ready_r && !move_fire_s && !bus.clear;
    assign load_ok_s    = idx_ok(bus.load_col, NUM_COLS);
    assign load_c_s     = load_ok_s ? CW'(bus.load_col) : {CW{1'b0}};
    assign load_bad_s   = !load_ok_s || (height_r[load_c_s] == HW'(COL_DEPTH)) ||
                          (bus.load_card[3:0] == 4'd0) || (bus.load_card[3:0] > 4'd13);

    assign src_type_s    = src_r[IDX_W+1:IDX_W];
    assign dst_type_s    = dst_r[IDX_W+1:IDX_W];
    assign src_col_ok_s  = idx_ok(src_r[IDX_W-1:0], NUM_COLS);
    assign dst_col_ok_s  = idx_ok(dst_r[IDX_W-1:0], NUM_COLS);
    assign src_free_ok_s = idx_ok(src_r[IDX_W-1:0], NUM_FREE);
    assign dst_free_ok_s = idx_ok(dst_r[IDX_W-1:0], NUM_FREE);
    assign src_c_s = src_col_ok_s  ? CW'(src_r[IDX_W-1:0]) : {CW{1'b0}};
    assign dst_c_s = dst_col_ok_s  ? CW'(dst_r[IDX_W-1:0]) : {CW{1'b0}};
    assign src_f_s = src_free_ok_s ? FW'(src_r[IDX_W-1:0]) : {FW{1'b0}};
    assign dst_f_s = dst_free_ok_s ? FW'(dst_r[IDX_W-1:0]) : {FW{1'b0}};

    // top card of every column (rank 0 when the column is empty)
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            if (height_r[c] == HW'(0)) top_s[c] = 6'd0;
            else                       top_s[c] = col_r[c][DW'(height_r[c] - HW'(1))];
        end
    end

    // legality of the latched request and its result code, highest priority first
    always_comb begin
        case (src_type_s)
            T_TAB:   src_card_s = top_s[src_c_s];
            T_FREE:  src_card_s = free_r[src_f_s];
            default: src_card_s = 6'd0;
        endcase
        dst_top_s  = top_s[dst_c_s];
        dst_full_s = (dst_type_s == T_TAB) && (height_r[dst_c_s] == HW'(COL_DEPTH));
        case (dst_type_s)
            T_TAB:   fits_s = (dst_top_s[3:0] == 4'd0) ||
                              ((dst_top_s[3:0] == src_card_s[3:0] + 4'd1) && (dst_top_s[5] != src_card_s[5]));
            T_FREE:  fits_s = (free_r[dst_f_s][3:0] == 4'd0);
            T_HOME:  fits_s = (home_r[src_card_s[5:4]] + 4'd1 == src_card_s[3:0]);
            default: fits_s = 1'b0;
        endcase
        bad_s = (src_type_s == T_BAD) || (src_type_s == T_HOME) || (dst_type_s == T_BAD) ||
                ((src_type_s == T_TAB)  && !src_col_ok_s)  || ((dst_type_s == T_TAB)  && !dst_col_ok_s) ||
                ((src_type_s == T_FREE) && !src_free_ok_s) || ((dst_type_s == T_FREE) && !dst_free_ok_s);
        if (bad_s)                            code_s = 3'd4;
        else if (src_r == dst_r)              code_s = 3'd3;
        else if (src_card_s[3:0] == 4'd0)     code_s = 3'd1;
        else if (dst_full_s)                  code_s = 3'd5;
        else if (!fits_s)                     code_s = 3'd2;
        else                                  code_s = 3'd0;
        legal_s = (code_s == 3'd0);
    end

    assign commit_s = (state_r == S_CHECK) && legal_s;

`ifdef FREECELL_AUTO_HOME_EN
    logic          auto_found_s, auto_free_s;
    logic [CW-1:0] auto_c_s;
    logic [FW-1:0] auto_f_s;
    logic [5:0]    auto_card_s;

    // first card (tableau tops, then free cells, lowest index first) that fits home
    always_comb begin
        auto_found_s = 1'b0;
        auto_free_s  = 1'b0;
        auto_c_s     = {CW{1'b0}};
        auto_f_s     = {FW{1'b0}};
        auto_card_s  = 6'd0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!auto_found_s && (top_s[c][3:0] != 4'd0) &&
                (top_s[c][3:0] == home_r[top_s[c][5:4]] + 4'd1)) begin
                auto_found_s = 1'b1;
                auto_c_s     = CW'(c);
                auto_card_s  = top_s[c];
            end else begin
                auto_found_s = auto_found_s;
            end
        end
        for (int f = 0; f < NUM_FREE; f++) begin
            if (!auto_found_s && (free_r[f][3:0] != 4'd0) &&
                (free_r[f][3:0] == home_r[free_r[f][5:4]] + 4'd1)) begin
                auto_found_s = 1'b1;
                auto_free_s  = 1'b1;
                auto_f_s     = FW'(f);
                auto_card_s  = free_r[f];
            end else begin
                auto_found_s = auto_found_s;
            end
        end
    end
    assign auto_move_s = (state_r == S_AUTO) && auto_found_s;
`else
    assign auto_move_s = 1'b0;
`endif

    // next-state logic of the request FSM
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = move_fire_s ? S_CHECK : S_IDLE;
`ifdef FREECELL_AUTO_HOME_EN
            S_CHECK: state_next_s = legal_s ? S_AUTO : S_RESP;
            S_AUTO:  state_next_s = auto_found_s ? S_AUTO : S_RESP;
`else
            S_CHECK: state_next_s = S_RESP;
`endif
            S_RESP:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // board storage: move commit, auto-home sweep, clear and column loads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                height_r[c] <= HW'(0);
                for (int d = 0; d < COL_DEPTH; d++) col_r[c][d] <= 6'd0;
            end
            for (int f = 0; f < NUM_FREE; f++) free_r[f] <= 6'd0;
            for (int h = 0; h < 4; h++) home_r[h] <= 4'd0;
        end else if (commit_s) begin
            if (src_type_s == T_TAB) height_r[src_c_s] <= height_r[src_c_s] - HW'(1);
            else                     free_r[src_f_s] <= 6'd0;
            case (dst_type_s)
                T_TAB: begin
                    col_r[dst_c_s][DW'(height_r[dst_c_s])] <= src_card_s;
                    height_r[dst_c_s] <= height_r[dst_c_s] + HW'(1);
                end
                T_FREE:  free_r[dst_f_s] <= src_card_s;
                T_HOME:  home_r[src_card_s[5:4]] <= src_card_s[3:0];
                default: home_r[0] <= home_r[0];
            endcase
`ifdef FREECELL_AUTO_HOME_EN
        end else if (auto_move_s) begin
            if (auto_free_s) free_r[auto_f_s] <= 6'd0;
            else             height_r[auto_c_s] <= height_r[auto_c_s] - HW'(1);
            home_r[auto_card_s[5:4]] <= auto_card_s[3:0];
`endif
        end else if (clear_fire_s) begin
            for (int c = 0; c < NUM_COLS; c++) height_r[c] <= HW'(0);
            for (int f = 0; f < NUM_FREE; f++) free_r[f] <= 6'd0;
            for (int h = 0; h < 4; h++) home_r[h] <= 4'd0;
        end else if (load_fire_s && !load_bad_s) begin
            col_r[load_c_s][DW'(height_r[load_c_s])] <= bus.load_card;
            height_r[load_c_s] <= height_r[load_c_s] + HW'(1);
        end
    end

    // FSM state, request latch, registered status/response outputs, counter, win
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            src_r        <= '0;
            dst_r        <= '0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_legal_r <= 1'b0;
            resp_code_r  <= 3'd0;
            load_err_r   <= 1'b0;
            count_r      <= {CNT_W{1'b0}};
            win_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ready_r      <= (state_next_s == S_IDLE);
            busy_r       <= (state_next_s != S_IDLE);
            resp_valid_r <= (state_next_s == S_RESP);
            load_err_r   <= load_fire_s && load_bad_s;
            if (move_fire_s) begin
                src_r <= bus.move_src;
                dst_r <= bus.move_dst;
            end
            if (state_r == S_CHECK) begin
                resp_legal_r <= legal_s;
                resp_code_r  <= code_s;
            end else if (state_next_s == S_IDLE) begin
                resp_legal_r <= 1'b0;
                resp_code_r  <= 3'd0;
            end
            if (clear_fire_s)                                        count_r <= {CNT_W{1'b0}};
            else if ((commit_s || auto_move_s) && (count_r != {CNT_W{1'b1}})) count_r <= count_r + CNT_W'(1);
            if (clear_fire_s) win_r <= 1'b0;
            else              win_r <= (home_r[0] == 4'd13) && (home_r[1] == 4'd13) &&
                                       (home_r[2] == 4'd13) && (home_r[3] == 4'd13);
        end
    end

    assign bus.load_ready = ready_r;
    assign bus.move_ready = ready_r;
    assign bus.load_err   = load_err_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_legal = resp_legal_r;
    assign bus.resp_code  = resp_code_r;
    assign bus.move_count = count_r;
    assign bus.win        = win_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_freecell_engine.sv
// Directed testbench for freecell_engine (default build, auto-home disabled).
// IDX_W is widened to 4 so that out-of-range tableau indices 8 and 9 are encodable.
module tb_freecell_engine;
    localparam int IW = 4;
    localparam logic [1:0] TAB = 2'b00, BADT = 2'b01, FREE = 2'b10, HOME = 2'b11;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    logic       m_legal;
    logic [2:0] m_code;
    logic       m_win;
    int         m_lat;
    logic       l_err;

    freecell_if #(.IDX_W(IW), .CNT_W(16)) bus ();

    freecell_engine #(.NUM_COLS(8), .COL_DEPTH(19), .NUM_FREE(4), .IDX_W(IW), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] card(input logic [1:0] s, input logic [3:0] r);
        return {s, r};
    endfunction

    function automatic logic [IW+1:0] loc(input logic [1:0] t, input logic [IW-1:0] i);
        return {t, i};
    endfunction

    task automatic do_load(input logic [IW-1:0] col, input logic [5:0] c);
        @(negedge clock);
        bus.load_valid = 1'b1; bus.load_col = col; bus.load_card = c;
        @(negedge clock);
        bus.load_valid = 1'b0;
        l_err = bus.load_err;
    endtask

    task automatic do_move(input logic [IW+1:0] s, input logic [IW+1:0] d);
        m_legal = 1'b0; m_code = 3'd7; m_win = 1'b0; m_lat = 0;
        @(negedge clock);
        bus.move_valid = 1'b1; bus.move_src = s; bus.move_dst = d;
        @(negedge clock);
        bus.move_valid = 1'b0;
        m_lat = 1;
        while (bus.resp_valid !== 1'b1 && m_lat < 20) begin
            @(negedge clock);
            m_lat++;
        end
        if (bus.resp_valid === 1'b1) begin
            m_legal = bus.resp_legal; m_code = bus.resp_code; m_win = bus.win;
            @(negedge clock);
        end else begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: no resp_valid within %0d cycles for src=%0h dst=%0h", m_lat, s, d);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.clear = 1'b0; bus.load_valid = 1'b0; bus.load_col = '0; bus.load_card = 6'd0;
        bus.move_valid = 1'b0; bus.move_src = '0; bus.move_dst = '0;
        repeat (2) @(negedge clock);
        n_checks++; if ({bus.load_ready, bus.move_ready, bus.resp_valid, bus.resp_legal, bus.load_err, bus.win, bus.busy} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 0000000", {bus.load_ready, bus.move_ready, bus.resp_valid, bus.resp_legal, bus.load_err, bus.win, bus.busy}); end
        n_checks++; if (bus.move_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.move_count); end
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if ({bus.load_ready, bus.move_ready, bus.busy} !== 3'b110) begin
            n_fail++; $display("FAIL idle_ready: got %b expected 110", {bus.load_ready, bus.move_ready, bus.busy}); end
    endtask

    task automatic test_home_move;
        do_load(4'd0, card(2'b10, 4'd2));
        n_checks++; if (l_err !== 1'b0) begin n_fail++; $display("FAIL load_ok: got err=%b expected 0", l_err); end
        do_load(4'd0, card(2'b00, 4'd1));
        do_move(loc(TAB, 4'd0), loc(HOME, 4'd0));
        exp_cnt++;
        n_checks++; if ({m_legal, m_code} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL ace_home: got legal=%b code=%0d expected legal=1 code=0", m_legal, m_code); end
        n_checks++; if (m_lat !== 2) begin n_fail++; $display("FAIL latency: got %0d expected 2", m_lat); end
        n_checks++; if (bus.move_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL count_1: got %0d expected %0d", bus.move_count, exp_cnt); end
        do_move(loc(TAB, 4'd0), loc(FREE, 4'd0));
        exp_cnt++;
        n_checks++; if (m_code !== 3'd0) begin n_fail++; $display("FAIL col0_one_left: got code %0d expected 0", m_code); end
        do_move(loc(TAB, 4'd0), loc(FREE, 4'd1));
        n_checks++; if (m_code !== 3'd1) begin n_fail++; $display("FAIL col0_empty: got code %0d expected 1", m_code); end
        do_load(4'd3, card(2'b00, 4'd2));
        do_move(loc(TAB, 4'd3), loc(HOME, 4'd5));
        exp_cnt++;
        n_checks++; if ({m_legal, m_code} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL two_spades_home: got legal=%b code=%0d expected legal=1 code=0", m_legal, m_code); end
    endtask

    task automatic test_tableau;
        do_load(4'd1, card(2'b00, 4'd8));
        do_load(4'd2, card(2'b10, 4'd7));
        do_move(loc(TAB, 4'd2), loc(TAB, 4'd1));
        exp_cnt++;
        n_checks++; if ({m_legal, m_code} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL h7_on_s8: got legal=%b code=%0d expected legal=1 code=0", m_legal, m_code); end
        do_load(4'd4, card(2'b00, 4'd7));
        do_load(4'd5, card(2'b01, 4'd6));
        do_move(loc(TAB, 4'd5), loc(FREE, 4'd1));
        exp_cnt++;
        n_checks++; if (m_code !== 3'd0) begin n_fail++; $display("FAIL c6_to_free: got code %0d expected 0", m_code); end
        do_move(loc(FREE, 4'd1), loc(TAB, 4'd4));
        n_checks++; if ({m_legal, m_code} !== {1'b0, 3'd2}) begin n_fail++; $display("FAIL c6_on_s7: got legal=%b code=%0d expected legal=0 code=2", m_legal, m_code); end
        do_move(loc(FREE, 4'd1), loc(TAB, 4'd1));
        exp_cnt++;
        n_checks++; if (m_code !== 3'd0) begin n_fail++; $display("FAIL c6_on_h7: got code %0d expected 0", m_code); end
        n_checks++; if (bus.move_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL count_tab: got %0d expected %0d", bus.move_count, exp_cnt); end
    endtask

    task automatic test_empty_source;
        do_move(loc(FREE, 4'd3), loc(TAB, 4'd0));
        n_checks++; if ({m_legal, m_code} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL free3_empty: got legal=%b code=%0d expected legal=0 code=1", m_legal, m_code); end
        n_checks++; if (bus.move_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL count_unchanged: got %0d expected %0d", bus.move_count, exp_cnt); end
        do_move(loc(TAB, 4'd0), loc(FREE, 4'd3));
        n_checks++; if (m_code !== 3'd1) begin n_fail++; $display("FAIL tab0_still_empty: got code %0d expected 1", m_code); end
    endtask

    task automatic test_encoding;
        logic [IW+1:0] srcs [8];
        logic [IW+1:0] dsts [8];
        logic [2:0]    exps [8];
        srcs[0] = loc(TAB, 4'd4);  dsts[0] = loc(TAB, 4'd4);  exps[0] = 3'd3;
        srcs[1] = loc(BADT, 4'd0); dsts[1] = loc(TAB, 4'd0);  exps[1] = 3'd4;
        srcs[2] = loc(TAB, 4'd9);  dsts[2] = loc(FREE, 4'd2); exps[2] = 3'd4;
        srcs[3] = loc(FREE, 4'd0); dsts[3] = loc(TAB, 4'd8);  exps[3] = 3'd4;
        srcs[4] = loc(FREE, 4'd4); dsts[4] = loc(TAB, 4'd0);  exps[4] = 3'd4;
        srcs[5] = loc(HOME, 4'd0); dsts[5] = loc(FREE, 4'd2); exps[5] = 3'd4;
        srcs[6] = loc(TAB, 4'd6);  dsts[6] = loc(TAB, 4'd6);  exps[6] = 3'd3;
        srcs[7] = loc(BADT, 4'd1); dsts[7] = loc(BADT, 4'd1); exps[7] = 3'd4;
        for (int i = 0; i < 8; i++) begin
            do_move(srcs[i], dsts[i]);
            n_checks++; if ({m_legal, m_code} !== {1'b0, exps[i]}) begin
                n_fail++; $display("FAIL encoding_%0d: got legal=%b code=%0d expected legal=0 code=%0d", i, m_legal, m_code, exps[i]); end
        end
        do_move(loc(FREE, 4'd0), loc(FREE, 4'd3));
        exp_cnt++;
        n_checks++; if (m_code !== 3'd0) begin n_fail++; $display("FAIL last_free_index: got code %0d expected 0", m_code); end
        n_checks++; if (bus.move_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL count_enc: got %0d expected %0d", bus.move_count, exp_cnt); end
    endtask

    task automatic test_column_full;
        int errs = 0;
        for (int i = 0; i < 19; i++) begin
            do_load(4'd7, card(2'(i % 4), 4'(i % 13 + 1)));
            if (l_err !== 1'b0) errs++;
        end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL fill_col7: got %0d load errors expected 0", errs); end
        do_load(4'd7, card(2'b00, 4'd1));
        n_checks++; if (l_err !== 1'b1) begin n_fail++; $display("FAIL overfill_err: got %b expected 1", l_err); end
        @(negedge clock);
        n_checks++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b expected 0", bus.load_err); end
        do_load(4'd6, card(2'b00, 4'd0));
        n_checks++; if (l_err !== 1'b1) begin n_fail++; $display("FAIL rank0_err: got %b expected 1", l_err); end
        do_load(4'd6, card(2'b00, 4'd14));
        n_checks++; if (l_err !== 1'b1) begin n_fail++; $display("FAIL rank14_err: got %b expected 1", l_err); end
        do_load(4'd8, card(2'b00, 4'd5));
        n_checks++; if (l_err !== 1'b1) begin n_fail++; $display("FAIL badcol_err: got %b expected 1", l_err); end
        do_move(loc(TAB, 4'd6), loc(FREE, 4'd2));
        n_checks++; if (m_code !== 3'd1) begin n_fail++; $display("FAIL rejected_not_pushed: got code %0d expected 1", m_code); end
        do_move(loc(FREE, 4'd3), loc(TAB, 4'd7));
        n_checks++; if ({m_legal, m_code} !== {1'b0, 3'd5}) begin n_fail++; $display("FAIL dst_full: got legal=%b code=%0d expected legal=0 code=5", m_legal, m_code); end
        do_move(loc(FREE, 4'd1), loc(TAB, 4'd7));
        n_checks++; if (m_code !== 3'd1) begin n_fail++; $display("FAIL empty_over_full: got code %0d expected 1", m_code); end
    endtask

    task automatic test_clear;
        @(negedge clock);
        bus.clear = 1'b1; bus.load_valid = 1'b1; bus.load_col = 4'd2; bus.load_card = card(2'b00, 4'd1);
        @(negedge clock);
        bus.clear = 1'b0; bus.load_valid = 1'b0;
        exp_cnt = 0;
        n_checks++; if (bus.move_count !== 16'd0) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", bus.move_count); end
        do_move(loc(TAB, 4'd2), loc(HOME, 4'd0));
        n_checks++; if (m_code !== 3'd1) begin n_fail++; $display("FAIL load_ignored_on_clear: got code %0d expected 1", m_code); end
        do_move(loc(TAB, 4'd1), loc(FREE, 4'd0));
        n_checks++; if (m_code !== 3'd1) begin n_fail++; $display("FAIL clear_col1: got code %0d expected 1", m_code); end
        do_move(loc(FREE, 4'd3), loc(TAB, 4'd0));
        n_checks++; if (m_code !== 3'd1) begin n_fail++; $display("FAIL clear_free3: got code %0d expected 1", m_code); end
    endtask

    task automatic test_back_to_back_win;
        int errs = 0;
        int illegal = 0;
        for (int s = 0; s < 4; s++)
            for (int r = 13; r >= 1; r--) begin
                do_load(4'(s), card(2'(s), 4'(r)));
                if (l_err !== 1'b0) errs++;
            end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL deal_loads: got %0d load errors expected 0", errs); end
        for (int r = 1; r <= 13; r++)
            for (int s = 0; s < 4; s++) begin
                do_move(loc(TAB, 4'(s)), loc(HOME, 4'd0));
                if (m_legal !== 1'b1) illegal++;
                exp_cnt++;
            end
        n_checks++; if (illegal !== 0) begin n_fail++; $display("FAIL home_run: got %0d illegal moves expected 0", illegal); end
        n_checks++; if (m_win !== 1'b0) begin n_fail++; $display("FAIL win_during_resp: got %b expected 0", m_win); end
        n_checks++; if (bus.win !== 1'b1) begin n_fail++; $display("FAIL win_after_resp: got %b expected 1", bus.win); end
        n_checks++; if (bus.move_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL count_52: got %0d expected %0d", bus.move_count, exp_cnt); end
    endtask

    task automatic test_reset_mid_check;
        int resp_seen = 0;
        do_load(4'd0, card(2'b01, 4'd5));
        @(negedge clock);
        bus.move_valid = 1'b1; bus.move_src = loc(TAB, 4'd0); bus.move_dst = loc(FREE, 4'd0);
        @(negedge clock);
        bus.move_valid = 1'b0;
        n_checks++; if ({bus.busy, bus.move_ready} !== 2'b10) begin n_fail++; $display("FAIL in_check: got busy,ready=%b expected 10", {bus.busy, bus.move_ready}); end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (bus.resp_valid !== 1'b0) resp_seen++;
        end
        n_checks++; if (resp_seen !== 0) begin n_fail++; $display("FAIL reset_abort: got %0d resp_valid cycles expected 0", resp_seen); end
        n_checks++; if ({bus.win, bus.busy, bus.move_count} !== 18'd0) begin
            n_fail++; $display("FAIL reset_state: got win=%b busy=%b count=%0d expected 0 0 0", bus.win, bus.busy, bus.move_count); end
        reset = 1'b0;
        @(negedge clock);
        do_move(loc(TAB, 4'd0), loc(FREE, 4'd0));
        n_checks++; if (m_code !== 3'd1) begin n_fail++; $display("FAIL reset_clears_board: got code %0d expected 1", m_code); end
    endtask

    initial begin
        test_reset;
        test_home_move;
        test_tableau;
        test_empty_source;
        test_encoding;
        test_column_full;
        test_clear;
        test_back_to_back_win;
        test_reset_mid_check;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
